step_dir_ctrl: RTL and testbench



---
 rtl/step_dir_ctrl.sv | 151 +++++++++++++++
 tb/tb_step_dir_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_ctrl.sv
// step_dir_ctrl: front end for the ring/bidirectional counter.
// It synchronises and debounces the raw step and direction buttons, toggles
// the direction on each accepted direction press, and runs an auto-step
// prescaler. The results are merged into a registered one-cycle step pulse
// and a registered direction level.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   btn_step in   raw bouncing step button, active high
//   btn_dir  in   raw bouncing direction button, active high
//   auto_en  in   synchronous auto-step enable
//   step     out  registered one-cycle advance pulse
//   dir      out  registered direction (0 = up, 1 = down)

// step_dir_deb: 2-flop synchroniser followed by a debounce FSM.
// Ports: clk, rst_n, raw (async button), press (one-cycle accepted-press event,
// valid in the cycle before the FSM enters PRESSED).
module step_dir_deb #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    typedef enum logic [1:0] {IDLE, ARM, PRESSED, REL} deb_state_t;

    localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    deb_state_t       state;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                end
                ARM: begin
                    if (!s2)
                        state <= IDLE;
                    else if (cnt == LAST)
                        state <= PRESSED;
                    else
                        cnt <= cnt + 1'b1;
                end
                PRESSED: begin
                    if (!s2) begin
                        state <= REL;
                        cnt   <= '0;
                    end
                end
                REL: begin
                    if (s2)
                        state <= PRESSED;
                    else if (cnt == LAST)
                        state <= IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Event is decoded from the ARM->PRESSED transition so the consumer can
    // register it on the very edge the FSM accepts the press.
    assign press = (state == ARM) && s2 && (cnt == LAST);
endmodule

module step_dir_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 16,
    parameter int PRESCALE   = 8,
    parameter int PRE_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_step,
    input  logic btn_dir,
    input  logic auto_en,
    output logic step,
    output logic dir
);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic             step_press;
    logic             dir_press;
    logic [PRE_W-1:0] pre;
    logic             auto_wrap;

    step_dir_deb #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_step (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .press (step_press)
    );

    step_dir_deb #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_dir (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_dir),
        .press (dir_press)
    );

    assign auto_wrap = auto_en && (pre == PRE_LAST);

    // Dropping auto_en clears the prescaler outright, so a partial period
    // never yields a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre <= '0;
        else if (!auto_en || auto_wrap)
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= 1'b0;
            dir  <= 1'b0;
        end else begin
            step <= step_press | auto_wrap;
            dir  <= dir ^ dir_press;
        end
    end
endmodule

// File: tb/tb_step_dir_ctrl.sv
// Self-checking bench for step_dir_ctrl: directed scenarios plus randomized
// button/auto_en waveforms, compared every cycle against a run-length
// debounce model and a cycle-count auto-step model.
module tb_step_dir_ctrl;
    localparam int DEB_CYCLES = 4;
    localparam int PRESCALE   = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_step;
    logic btn_dir;
    logic auto_en;
    logic step;
    logic dir;

    int n_checks = 0;
    int n_errors = 0;
    int steps_seen = 0;
    bit chk_en = 1'b0;

    step_dir_ctrl #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (16),
        .PRESCALE   (PRESCALE),
        .PRE_W      (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_step (btn_step),
        .btn_dir  (btn_dir),
        .auto_en  (auto_en),
        .step     (step),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model. A button's accepted level flips once the synchronised
    // sample has disagreed with it for DEB_CYCLES+1 consecutive edges; a flip
    // to 1 is a press event. Auto-step fires on every PRESCALE-th consecutive
    // edge with auto_en high.
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_acc[2];
    int   m_run[2];
    logic m_ev [2];
    int   m_auto_n;
    logic exp_step;
    logic exp_dir;

    function automatic void model_clear();
        for (int b = 0; b < 2; b++) begin
            m_s1[b]  = 1'b0;
            m_s2[b]  = 1'b0;
            m_acc[b] = 1'b0;
            m_run[b] = 0;
            m_ev[b]  = 1'b0;
        end
        m_auto_n = 0;
        exp_step = 1'b0;
        exp_dir  = 1'b0;
    endfunction

    initial model_clear();

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            logic raw[2];
            logic seen;
            logic ev_auto;
            raw[0] = btn_step;
            raw[1] = btn_dir;
            for (int b = 0; b < 2; b++) begin
                seen     = m_s2[b];
                m_s2[b]  = m_s1[b];
                m_s1[b]  = raw[b];
                m_ev[b]  = 1'b0;
                if (seen != m_acc[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB_CYCLES + 1) begin
                        m_acc[b] = seen;
                        m_run[b] = 0;
                        m_ev[b]  = seen;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            if (auto_en) begin
                m_auto_n++;
                ev_auto = (m_auto_n % PRESCALE) == 0;
            end else begin
                m_auto_n = 0;
                ev_auto  = 1'b0;
            end
            exp_step = m_ev[0] | ev_auto;
            exp_dir  = exp_dir ^ m_ev[1];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("step", {31'b0, step}, {31'b0, exp_step});
            check("dir", {31'b0, dir}, {31'b0, exp_dir});
            if (step === 1'b1)
                steps_seen++;
        end
    end

    // Inputs change on the falling edge and hold for n rising edges.
    task automatic hold(input logic bs, input logic bd, input logic ae, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_step = bs;
            btn_dir  = bd;
            auto_en  = ae;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_step", {31'b0, step}, 32'd0);
        check("rst_dir", {31'b0, dir}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_step = 1'b0;
        btn_dir  = 1'b0;
        auto_en  = 1'b0;
        #1 chk_en = 1'b1;
        check("por_step", {31'b0, step}, 32'd0);
        check("por_dir", {31'b0, dir}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(0, 0, 0, 5);

        // Clean press held 20 cycles: exactly one pulse.
        steps_seen = 0;
        hold(1, 0, 0, 20);
        hold(0, 0, 0, 15);
        check("clean_press_count", steps_seen, 32'd1);

        // Bouncy press and bouncy release: one pulse in total.
        steps_seen = 0;
        for (int i = 0; i < 10; i++) hold(i[0] ? 1'b0 : 1'b1, 0, 0, 1);
        hold(1, 0, 0, 15);
        for (int i = 0; i < 8; i++) hold(i[0] ? 1'b1 : 1'b0, 0, 0, 1);
        hold(0, 0, 0, 15);
        check("bounce_count", steps_seen, 32'd1);

        // Two direction presses; no step pulses.
        steps_seen = 0;
        hold(0, 1, 0, 10);
        hold(0, 0, 0, 20);
        check("dir_after_first", {31'b0, dir}, 32'd1);
        hold(0, 1, 0, 10);
        hold(0, 0, 0, 20);
        check("dir_after_second", {31'b0, dir}, 32'd0);
        check("dir_no_step", steps_seen, 32'd0);

        // Glitches of 1..DEB_CYCLES+2 cycles: only the long ones count.
        for (int len = 1; len <= DEB_CYCLES + 2; len++) begin
            steps_seen = 0;
            hold(1, 0, 0, len);
            hold(0, 0, 0, 15);
            check("glitch_count", steps_seen, (len >= DEB_CYCLES + 1) ? 32'd1 : 32'd0);
        end

        // Auto-run for 40 cycles, then dropped mid-count.
        steps_seen = 0;
        hold(0, 0, 1, 40);
        hold(0, 0, 1, 4);
        hold(0, 0, 0, 20);
        check("auto_count", steps_seen, 32'd5);

        // Step and dir pressed together, landing on the second auto wrap.
        steps_seen = 0;
        hold(0, 0, 1, 9);
        hold(1, 1, 1, 12);
        hold(0, 0, 0, 20);
        check("coincide_count", steps_seen, 32'd2);
        check("coincide_dir", {31'b0, dir}, 32'd1);

        // Reset while the step press is still in its arming phase.
        hold(1, 0, 0, 5);
        reset_pulse();
        steps_seen = 0;
        hold(1, 0, 0, 12);
        hold(0, 0, 0, 10);
        check("post_reset_count", steps_seen, 32'd1);

        // Randomized segments over all three inputs.
        for (int seg = 0; seg < 400; seg++) begin
            hold($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(1, 10));
            if (seg == 200) reset_pulse();
        end
        hold(0, 0, 0, 15);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
